// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end: datapath width,
// instruction-memory geometry and the fetch FSM state encoding.
package mips_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned IMEM_DEPTH  = 256;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential step, PC-relative branch target
// and region-preserving jump target.
module pc_next_calc
    import mips_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_out,
    input  logic             jump_sel,
    input  logic             branch_sel,
    input  logic [15:0]      branch_imm,
    input  logic [25:0]      jump_index,
    output logic [WIDTH-1:0] next_pc
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);

    logic [WIDTH-1:0] pc_plus4_s;
    logic [WIDTH-1:0] link_s;
    logic [WIDTH-1:0] offset_s;
    logic [WIDTH-1:0] branch_target_s;
    logic [WIDTH-1:0] jump_target_s;

    // Targets are relative to the word after the one being redirected in decode.
    assign pc_plus4_s      = pc + STEP;
    assign link_s          = pc_out + STEP;
    assign offset_s        = {{(WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};
    assign branch_target_s = link_s + offset_s;
    assign jump_target_s   = {link_s[WIDTH-1:28], jump_index, 2'b00};

    // Jump has priority over a simultaneously taken branch.
    always_comb begin
        next_pc = pc_plus4_s;
        if (jump_sel) begin
            next_pc = jump_target_s;
        end else if (branch_sel) begin
            next_pc = branch_target_s;
        end else begin
            next_pc = pc_plus4_s;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, fetch FSM and a one-entry output
// register handed to decode over a valid/ready handshake.
module pc_fetch
    import mips_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter int               DEPTH    = IMEM_DEPTH,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_en,
    output logic [WIDTH-1:0] pc_A,
    input  logic [WIDTH-1:0] instr_in,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             branch_taken,
    input  logic [15:0]      branch_imm,
    input  logic             jump_en,
    input  logic [25:0]      jump_index,
    output logic             addr_err
);

    localparam logic [WIDTH:0] PC_LIMIT = (WIDTH+1)'(DEPTH * INSTR_BYTES);

    fetch_state_e     state_r;
    fetch_state_e     state_next_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] instr_r;
    logic [WIDTH-1:0] pc_out_r;
    logic             valid_r;
    logic             addr_err_r;
    logic [WIDTH-1:0] next_pc_s;
    logic             in_range_s;
    logic             fire_s;
    logic             redirect_s;
    logic             load_s;

    assign in_range_s = ({1'b0, pc_r} < PC_LIMIT);
    assign fire_s     = valid_r & out_ready;
    assign redirect_s = fire_s & (jump_en | branch_taken);
    assign load_s     = (state_r == RUN) & (~valid_r | out_ready) & ~redirect_s & in_range_s;

    pc_next_calc #(
        .WIDTH (WIDTH)
    ) u_next (
        .pc         (pc_r),
        .pc_out     (pc_out_r),
        .jump_sel   (fire_s & jump_en),
        .branch_sel (fire_s & branch_taken),
        .branch_imm (branch_imm),
        .jump_index (jump_index),
        .next_pc    (next_pc_s)
    );

    // Fetch FSM next-state; leaving the memory range while running is terminal.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (fetch_en) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (!in_range_s) begin
                    state_next_s = HALT;
                end else if (!fetch_en) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            HALT:    state_next_s = HALT;
            default: state_next_s = IDLE;
        endcase
    end

    // State, PC and output register; a redirect drops the fall-through word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            instr_r    <= '0;
            pc_out_r   <= '0;
            valid_r    <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (load_s) begin
                instr_r  <= instr_in;
                pc_out_r <= pc_r;
                valid_r  <= 1'b1;
                pc_r     <= next_pc_s;
            end else if (redirect_s) begin
                valid_r  <= 1'b0;
                pc_r     <= next_pc_s;
            end else if (fire_s) begin
                valid_r  <= 1'b0;
            end
            if ((state_r == RUN) && (state_next_s == HALT)) begin
                addr_err_r <= 1'b1;
            end
        end
    end

    assign pc_A      = pc_r;
    assign instr_out = instr_r;
    assign pc_out    = pc_out_r;
    assign out_valid = valid_r;
    assign addr_err  = addr_err_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch with a combinational memory model.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] pc_A;
    logic [31:0] instr_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        out_valid;
    logic        out_ready;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump_en;
    logic [25:0] jump_index;
    logic        addr_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_en     (fetch_en),
        .pc_A         (pc_A),
        .instr_in     (instr_in),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump_en      (jump_en),
        .jump_index   (jump_index),
        .addr_err     (addr_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign instr_in = mem_word(pc_A);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".pc_out"}, pc_out, pc);
        check({tag, ".instr"}, instr_out, mem_word(pc));
    endtask

    task automatic expect_bubble(input string tag, input logic [31:0] pca);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".pc_A"}, pc_A, pca);
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
        branch_taken = 1'b0; branch_imm = 16'h0000; jump_en = 1'b0; jump_index = 26'h0;
        tick; tick;
        expect_bubble("rst", 32'h0);
        check("rst.pc_out", pc_out, 32'h0);
        check("rst.instr", instr_out, 32'h0);
        check("rst.err", {31'd0, addr_err}, 32'd0);

        // Streaming fetch
        rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        tick; expect_bubble("idle2run", 32'h0);
        tick; expect_word("seq0", 32'h00);
        tick; expect_word("seq1", 32'h04);
        tick; expect_word("seq2", 32'h08);
        check("seq2.pc_A", pc_A, 32'h0C);

        // Back-pressure holds the output word
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick; expect_word("stall", 32'h08);
            check("stall.pc_A", pc_A, 32'h0C);
        end
        out_ready = 1'b1;
        tick; expect_word("release", 32'h0C);
        tick; expect_word("seq4", 32'h10);
        tick; expect_word("seq5", 32'h14);

        // Forward branch: 0x18 + 0x18 = 0x30
        branch_taken = 1'b1; branch_imm = 16'h0006;
        tick; expect_bubble("br_fwd", 32'h30);
        branch_taken = 1'b0;
        tick; expect_word("br_fwd_tgt", 32'h30);

        // Backward branch: 0x34 - 0x20 = 0x14
        branch_taken = 1'b1; branch_imm = 16'hFFF8;
        tick; expect_bubble("br_back", 32'h14);
        branch_taken = 1'b0;
        tick; expect_word("br_back_tgt", 32'h14);

        // Branch to self: 0x18 - 4 = 0x14
        branch_taken = 1'b1; branch_imm = 16'hFFFF;
        tick; expect_bubble("br_self", 32'h14);
        branch_taken = 1'b0;
        tick; expect_word("br_self_tgt", 32'h14);

        for (int k = 1; k <= 4; k++) begin
            tick; expect_word("seq_j", 32'h14 + 32'(4 * k));
        end

        // Jump beats branch: {0x28[31:28], 5, 00} = 0x14
        jump_en = 1'b1; jump_index = 26'h0000005; branch_taken = 1'b1; branch_imm = 16'h0006;
        tick; expect_bubble("jmp", 32'h14);
        jump_en = 1'b0; branch_taken = 1'b0;
        tick; expect_word("jmp_tgt", 32'h14);

        // Jump near the top of memory, then run off the end
        jump_en = 1'b1; jump_index = 26'h00000F0;
        tick; expect_bubble("jmp_hi", 32'h3C0);
        jump_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick; expect_word("tail", 32'h3C0 + 32'(4 * k));
        end
        check("tail.err", {31'd0, addr_err}, 32'd0);
        tick; expect_bubble("halt", 32'h400);
        check("halt.err", {31'd0, addr_err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick; expect_bubble("halt_hold", 32'h400);
            check("halt_hold.err", {31'd0, addr_err}, 32'd1);
        end

        // Reset mid-stream with a held word
        rst_n = 1'b0; out_ready = 1'b0;
        tick; rst_n = 1'b1;
        tick; tick; expect_word("pre_rst", 32'h00);
        tick; expect_word("pre_rst_hold", 32'h00);
        rst_n = 1'b0;
        tick; expect_bubble("mid_rst", 32'h0);
        check("mid_rst.pc_out", pc_out, 32'h0);
        check("mid_rst.err", {31'd0, addr_err}, 32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        tick; expect_bubble("refetch_idle", 32'h0);
        tick; expect_word("refetch", 32'h00);

        // Pause: PC retained, held word stays presentable, then drains
        fetch_en = 1'b0; out_ready = 1'b0;
        tick; expect_word("pause", 32'h00);
        tick; expect_word("pause_hold", 32'h00);
        check("pause.pc_A", pc_A, 32'h04);
        out_ready = 1'b1;
        tick; expect_bubble("pause_drain", 32'h04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
